// File: rtl/ccff_chain_mem_param_if.sv
// Configuration-chain programming bus.
//   master : drives ccff_head, ccff_shift_en, ccff_rotate, ccff_commit;
//            observes ccff_tail, mem_out, mem_outb, shift_cnt, chain_full, commit_err.
//   slave  : the chain block itself (directions reversed).
// NUM_BITS must match the NUM_BITS of the attached ccff_chain_mem_param.
interface ccff_chain_mem_param_if #(
  parameter int unsigned NUM_BITS = 16
);
  localparam int unsigned CNT_W = $clog2(NUM_BITS + 1);

  logic                ccff_head;
  logic                ccff_shift_en;
  logic                ccff_rotate;
  logic                ccff_commit;
  logic                ccff_tail;
  logic [NUM_BITS-1:0] mem_out;
  logic [NUM_BITS-1:0] mem_outb;
  logic [CNT_W-1:0]    shift_cnt;
  logic                chain_full;
  logic                commit_err;

  modport master (
    output ccff_head, ccff_shift_en, ccff_rotate, ccff_commit,
    input  ccff_tail, mem_out, mem_outb, shift_cnt, chain_full, commit_err
  );

  modport slave (
    input  ccff_head, ccff_shift_en, ccff_rotate, ccff_commit,
    output ccff_tail, mem_out, mem_outb, shift_cnt, chain_full, commit_err
  );
endinterface

// File: rtl/ccff_chain_mem_param.sv
// Serial configuration chain with optional double-buffered outputs.
//   prog_clk   : programming clock, rising edge
//   prog_reset : asynchronous active-high reset
//   bus        : slave side of ccff_chain_mem_param_if
//                ccff_head/shift_en/rotate/commit in;
//                ccff_tail, mem_out, mem_outb, shift_cnt, chain_full, commit_err out.
// SHADOW=1: mem_out is a separate active register loaded by an accepted commit.
// SHADOW=0: mem_out taps the chain directly and commit is ignored.
module ccff_chain_mem_param #(
  parameter  int unsigned NUM_BITS = 16,
  parameter  bit          SHADOW   = 1'b1,
  localparam int unsigned CNT_W    = $clog2(NUM_BITS + 1)
) (
  input logic                    prog_clk,
  input logic                    prog_reset,
  ccff_chain_mem_param_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY,
    LOADING,
    FULL
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_BITS);

  state_t              state;
  logic [NUM_BITS-1:0] chain, chain_nxt;
  logic [NUM_BITS-1:0] active, active_nxt;
  logic [NUM_BITS-1:0] mem_w;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                err, err_nxt;
  logic                feed_bit;

  // The counter is the state register; the enum is a decode of it.
  always_comb begin
    if (cnt == '0)          state = EMPTY;
    else if (cnt == CNT_MAX) state = FULL;
    else                    state = LOADING;
  end

  assign feed_bit = bus.ccff_rotate ? chain[NUM_BITS-1] : bus.ccff_head;

  // A commit (shadow build only) takes priority over a same-cycle shift:
  // it is judged on the pre-edge count and the shift is dropped.
  always_comb begin
    chain_nxt  = chain;
    active_nxt = active;
    cnt_nxt    = cnt;
    err_nxt    = err;
    if (SHADOW && bus.ccff_commit) begin
      if (state == FULL) begin
        active_nxt = chain;
        cnt_nxt    = '0;
        err_nxt    = 1'b0;
      end else begin
        err_nxt    = 1'b1;
      end
    end else if (bus.ccff_shift_en) begin
      chain_nxt    = chain << 1;
      chain_nxt[0] = feed_bit;
      if (state != FULL) cnt_nxt = cnt + 1'b1;
    end
  end

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      chain  <= '0;
      active <= '0;
      cnt    <= '0;
      err    <= 1'b0;
    end else begin
      chain  <= chain_nxt;
      active <= active_nxt;
      cnt    <= cnt_nxt;
      err    <= err_nxt;
    end
  end

  assign mem_w          = SHADOW ? active : chain;
  assign bus.mem_out    = mem_w;
  assign bus.mem_outb   = ~mem_w;
  assign bus.ccff_tail  = chain[NUM_BITS-1];
  assign bus.shift_cnt  = cnt;
  assign bus.chain_full = (state == FULL);
  assign bus.commit_err = err;

endmodule

// File: tb/tb_ccff_chain_mem_param.sv
// Bench for ccff_chain_mem_param: NUM_BITS=4 with SHADOW=1 and SHADOW=0,
// plus a NUM_BITS=1 corner instance.
module tb_ccff_chain_mem_param;

  logic prog_clk   = 1'b0;
  logic prog_reset = 1'b0;
  always #5 prog_clk = ~prog_clk;

  ccff_chain_mem_param_if #(.NUM_BITS(4)) bus_s1 ();
  ccff_chain_mem_param_if #(.NUM_BITS(4)) bus_s0 ();
  ccff_chain_mem_param_if #(.NUM_BITS(1)) bus_n1 ();

  ccff_chain_mem_param #(.NUM_BITS(4), .SHADOW(1'b1)) u_dut_s1 (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .bus(bus_s1));
  ccff_chain_mem_param #(.NUM_BITS(4), .SHADOW(1'b0)) u_dut_s0 (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .bus(bus_s0));
  ccff_chain_mem_param #(.NUM_BITS(1), .SHADOW(1'b1)) u_dut_n1 (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .bus(bus_n1));

  typedef struct packed {
    logic       tail;
    logic [3:0] mem;
    logic [2:0] cnt;
    logic       full;
    logic       err;
  } exp_t;

  exp_t q_s1[$];
  exp_t q_s0[$];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state
  logic [3:0] m_chain = '0, m_act = '0;
  logic [2:0] m_cnt = '0;
  logic       m_err = 1'b0;
  logic [3:0] m0_chain = '0;
  logic [2:0] m0_cnt = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_s1();
    exp_t e;
    e.tail = m_chain[3];
    e.mem  = m_act;
    e.cnt  = m_cnt;
    e.full = (m_cnt == 3'd4);
    e.err  = m_err;
    q_s1.push_back(e);
  endtask

  task automatic push_s0();
    exp_t e;
    e.tail = m0_chain[3];
    e.mem  = m0_chain;
    e.cnt  = m0_cnt;
    e.full = (m0_cnt == 3'd4);
    e.err  = 1'b0;
    q_s0.push_back(e);
  endtask

  task automatic compare_s1(input string tag);
    exp_t e;
    logic [3:0] nb;
    e  = q_s1.pop_front();
    nb = ~e.mem;
    check({tag, ".tail"}, bus_s1.ccff_tail, e.tail);
    check({tag, ".mem"},  bus_s1.mem_out, e.mem);
    check({tag, ".memb"}, bus_s1.mem_outb, nb);
    check({tag, ".cnt"},  bus_s1.shift_cnt, e.cnt);
    check({tag, ".full"}, bus_s1.chain_full, e.full);
    check({tag, ".err"},  bus_s1.commit_err, e.err);
  endtask

  task automatic compare_s0(input string tag);
    exp_t e;
    logic [3:0] nb;
    e  = q_s0.pop_front();
    nb = ~e.mem;
    check({tag, ".tail"}, bus_s0.ccff_tail, e.tail);
    check({tag, ".mem"},  bus_s0.mem_out, e.mem);
    check({tag, ".memb"}, bus_s0.mem_outb, nb);
    check({tag, ".cnt"},  bus_s0.shift_cnt, e.cnt);
    check({tag, ".full"}, bus_s0.chain_full, e.full);
    check({tag, ".err"},  bus_s0.commit_err, e.err);
  endtask

  task automatic model_reset();
    m_chain = '0; m_act = '0; m_cnt = '0; m_err = 1'b0;
    m0_chain = '0; m0_cnt = '0;
  endtask

  // One clock of stimulus on the SHADOW=1 instance.
  task automatic step_s1(input logic head, input logic sh, input logic rot,
                         input logic cm, input string tag);
    bus_s1.ccff_head     = head;
    bus_s1.ccff_shift_en = sh;
    bus_s1.ccff_rotate   = rot;
    bus_s1.ccff_commit   = cm;
    if (cm) begin
      if (m_cnt == 3'd4) begin
        m_act = m_chain; m_cnt = '0; m_err = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end else if (sh) begin
      m_chain = {m_chain[2:0], rot ? m_chain[3] : head};
      if (m_cnt != 3'd4) m_cnt = m_cnt + 3'd1;
    end
    push_s1();
    @(posedge prog_clk);
    #1;
    compare_s1(tag);
    bus_s1.ccff_shift_en = 1'b0;
    bus_s1.ccff_rotate   = 1'b0;
    bus_s1.ccff_commit   = 1'b0;
  endtask

  // One clock of stimulus on the SHADOW=0 instance; commit never blocks a shift.
  task automatic step_s0(input logic head, input logic sh, input logic cm, input string tag);
    bus_s0.ccff_head     = head;
    bus_s0.ccff_shift_en = sh;
    bus_s0.ccff_rotate   = 1'b0;
    bus_s0.ccff_commit   = cm;
    if (sh) begin
      m0_chain = {m0_chain[2:0], head};
      if (m0_cnt != 3'd4) m0_cnt = m0_cnt + 3'd1;
    end
    push_s0();
    @(posedge prog_clk);
    #1;
    compare_s0(tag);
    bus_s0.ccff_shift_en = 1'b0;
    bus_s0.ccff_commit   = 1'b0;
  endtask

  initial begin
    logic [3:0] load_bits;
    logic [3:0] rb_tail;
    logic [3:0] want;

    bus_s1.ccff_head = 1'b0; bus_s1.ccff_shift_en = 1'b0;
    bus_s1.ccff_rotate = 1'b0; bus_s1.ccff_commit = 1'b0;
    bus_s0.ccff_head = 1'b0; bus_s0.ccff_shift_en = 1'b0;
    bus_s0.ccff_rotate = 1'b0; bus_s0.ccff_commit = 1'b0;
    bus_n1.ccff_head = 1'b0; bus_n1.ccff_shift_en = 1'b0;
    bus_n1.ccff_rotate = 1'b0; bus_n1.ccff_commit = 1'b0;

    // Reset takes effect without a clock edge
    #1 prog_reset = 1'b1;
    model_reset();
    push_s1(); push_s0();
    #1;
    compare_s1("rst");
    compare_s0("rst0");
    check("rst_n1.full", bus_n1.chain_full, 1'b0);
    check("rst_n1.memb", bus_n1.mem_outb, 1'b1);
    @(posedge prog_clk);
    #1 prog_reset = 1'b0;

    // Load 1,0,1,1 then commit
    load_bits = 4'b1101;  // index 0 is the first bit shifted in
    for (int i = 0; i < 4; i++) step_s1(load_bits[i], 1'b1, 1'b0, 1'b0, "load");
    check("load.full_pre", bus_s1.chain_full, 1'b1);
    check("load.mem_pre", bus_s1.mem_out, 4'b0000);
    step_s1(1'b0, 1'b0, 1'b0, 1'b1, "commit");
    check("commit.mem", bus_s1.mem_out, 4'b1011);
    check("commit.memb", bus_s1.mem_outb, 4'b0100);
    check("commit.cnt", bus_s1.shift_cnt, 3'd0);

    // Readback: tail seen before each rotate edge is 1,0,1,1
    rb_tail = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      check("rb.tail_seq", bus_s1.ccff_tail, rb_tail[i]);
      step_s1(1'b0, 1'b1, 1'b1, 1'b0, "rotate");
    end
    step_s1(1'b0, 1'b0, 1'b0, 1'b1, "rb_commit");
    check("rb.mem", bus_s1.mem_out, 4'b1011);
    check("rb.err", bus_s1.commit_err, 1'b0);

    // Early commit sets sticky error; a later accepted commit clears it
    step_s1(1'b0, 1'b1, 1'b0, 1'b0, "early_sh");
    step_s1(1'b1, 1'b1, 1'b0, 1'b0, "early_sh");
    step_s1(1'b0, 1'b0, 1'b0, 1'b1, "early_cm");
    check("early.err", bus_s1.commit_err, 1'b1);
    check("early.cnt", bus_s1.shift_cnt, 3'd2);
    check("early.mem", bus_s1.mem_out, 4'b1011);
    step_s1(1'b1, 1'b1, 1'b0, 1'b0, "early_sh2");
    step_s1(1'b0, 1'b1, 1'b0, 1'b0, "early_sh2");
    check("early.err_sticky", bus_s1.commit_err, 1'b1);
    step_s1(1'b0, 1'b0, 1'b0, 1'b1, "late_cm");
    check("late.err", bus_s1.commit_err, 1'b0);
    check("late.mem", bus_s1.mem_out, 4'b0110);

    // Shift and commit together: commit wins, chain not shifted
    load_bits = 4'b0110;
    for (int i = 0; i < 4; i++) step_s1(load_bits[i], 1'b1, 1'b0, 1'b0, "sim_load");
    step_s1(1'b1, 1'b1, 1'b0, 1'b1, "sim_both");
    want = 4'b0110;
    check("sim.mem", bus_s1.mem_out, want);
    check("sim.cnt", bus_s1.shift_cnt, 3'd0);
    check("sim.tail", bus_s1.ccff_tail, want[3]);

    // Randomised traffic including saturation beyond NUM_BITS shifts
    for (int i = 0; i < 60; i++)
      step_s1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0), "rand");

    // Reset pulsed between edges after 3 shifts
    step_s1(1'b0, 1'b0, 1'b0, 1'b1, "pre_rst_cm");
    for (int i = 0; i < 3; i++) step_s1(1'b1, 1'b1, 1'b0, 1'b0, "pre_rst");
    #2 prog_reset = 1'b1;
    model_reset();
    push_s1(); push_s0();
    #1;
    compare_s1("rst_mid");
    compare_s0("rst_mid0");
    #1 prog_reset = 1'b0;
    // First edge after reset is functional
    step_s1(1'b1, 1'b1, 1'b0, 1'b0, "post_rst");
    check("post_rst.cnt", bus_s1.shift_cnt, 3'd1);

    // SHADOW=0: mem_out follows the chain, commit ignored
    load_bits = 4'b0001;
    for (int i = 0; i < 4; i++) step_s0(load_bits[i], 1'b1, 1'b0, "s0_load");
    check("s0.mem", bus_s0.mem_out, 4'b1000);
    check("s0.full", bus_s0.chain_full, 1'b1);
    step_s0(1'b0, 1'b0, 1'b1, "s0_commit");
    check("s0.err", bus_s0.commit_err, 1'b0);
    step_s0(1'b1, 1'b1, 1'b1, "s0_sh_cm");
    step_s0(1'b0, 1'b0, 1'b1, "s0_commit2");

    // NUM_BITS=1: full after a single shift
    bus_n1.ccff_head = 1'b1; bus_n1.ccff_shift_en = 1'b1;
    @(posedge prog_clk); #1;
    bus_n1.ccff_shift_en = 1'b0;
    check("n1.full", bus_n1.chain_full, 1'b1);
    check("n1.cnt", bus_n1.shift_cnt, 1'b1);
    check("n1.tail", bus_n1.ccff_tail, 1'b1);
    check("n1.mem_pre", bus_n1.mem_out, 1'b0);
    bus_n1.ccff_commit = 1'b1;
    @(posedge prog_clk); #1;
    bus_n1.ccff_commit = 1'b0;
    check("n1.mem", bus_n1.mem_out, 1'b1);
    check("n1.cnt0", bus_n1.shift_cnt, 1'b0);
    check("n1.err", bus_n1.commit_err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
